// File: rtl/tx_pkg.sv
// Shared types and default timing for the double-buffered frame scheduler.
package tx_pkg;
    localparam int unsigned PAYLOAD   = 1024;
    localparam int unsigned FRAME_CYC = 1052;
    localparam int unsigned IFG_CYC   = 12;
    localparam int unsigned GAP_W     = 16;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, SENDING} half_state_t;
    typedef enum logic [1:0] {IDLE, LAUNCH, SEND} sched_state_t;
endpackage

// File: rtl/tx_gap_timer.sv
// Loadable down-counter; zero_c flags the decrement that lands on zero.
module tx_gap_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk125,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // A count already at zero also reports, so a stalled timer can never hang the scheduler.
    assign zero_c = dec && (cnt <= W'(1));

endmodule

// File: rtl/tx_frame_sched.sv
// Ping-pong payload buffer: fills one half while the transmitter sends the other,
// spacing frame launches by at least one frame plus inter-frame gap.
module tx_frame_sched #(
    parameter int unsigned PAYLOAD   = tx_pkg::PAYLOAD,
    parameter int unsigned FRAME_CYC = tx_pkg::FRAME_CYC,
    parameter int unsigned IFG_CYC   = tx_pkg::IFG_CYC
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_rdy,
    output logic        buf_we,
    output logic [10:0] buf_wa,
    output logic [7:0]  buf_wd,
    output logic        idx,
    output logic [15:0] frames_sent,
    output logic        ovf
);
    import tx_pkg::*;

    localparam int unsigned PTR_W    = 10;
    localparam int unsigned GAP_LOAD = FRAME_CYC + IFG_CYC - 1;

    half_state_t        half_st  [2];
    half_state_t        half_nxt [2];
    sched_state_t       state;
    sched_state_t       state_nxt;
    logic               fill_half;
    logic [PTR_W-1:0]   wptr;
    logic               wptr_last_c;
    logic               accept_c;
    logic               launch_c;
    logic               release_c;
    logic               gap_zero_c;
    logic [GAP_W-1:0]   gap_cnt;

    assign wr_rdy      = (half_st[fill_half] == EMPTY) || (half_st[fill_half] == FILLING);
    assign accept_c    = wr_valid & wr_rdy;
    assign wptr_last_c = (wptr == PTR_W'(PAYLOAD - 1));

    tx_gap_timer #(.W(GAP_W)) u_gap (
        .clk125   (clk125),
        .rst      (rst),
        .load     (launch_c),
        .load_val (GAP_W'(GAP_LOAD)),
        .dec      (state == SEND),
        .cnt      (gap_cnt),
        .zero_c   (gap_zero_c)
    );

    // Launch sequencer next-state.
    always_comb begin
        state_nxt = state;
        launch_c  = 1'b0;
        release_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && (half_st[~idx] == FULL)) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                launch_c  = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (gap_zero_c) begin
                    release_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fill, launch and release always touch different halves, so all three may apply together.
    always_comb begin
        half_nxt[0] = half_st[0];
        half_nxt[1] = half_st[1];
        if (accept_c) begin
            half_nxt[fill_half] = wptr_last_c ? FULL : FILLING;
        end
        if (launch_c) begin
            half_nxt[~idx] = SENDING;
        end
        if (release_c) begin
            half_nxt[idx] = EMPTY;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            half_st[0]  <= EMPTY;
            half_st[1]  <= EMPTY;
            idx         <= 1'b1;
            fill_half   <= 1'b0;
            wptr        <= '0;
            buf_we      <= 1'b0;
            buf_wa      <= '0;
            buf_wd      <= '0;
            frames_sent <= '0;
            ovf         <= 1'b0;
        end else begin
            state      <= state_nxt;
            half_st[0] <= half_nxt[0];
            half_st[1] <= half_nxt[1];
            buf_we     <= accept_c;
            if (accept_c) begin
                buf_wa <= {fill_half, wptr};
                buf_wd <= wr_data;
                if (wptr_last_c) begin
                    wptr      <= '0;
                    fill_half <= ~fill_half;
                end else begin
                    wptr <= wptr + PTR_W'(1);
                end
            end
            if (launch_c) begin
                idx         <= ~idx;
                frames_sent <= frames_sent + 16'd1;
            end
            if (wr_valid && !wr_rdy) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter: PAYLOAD, default 1024, payload bytes per frame (one buffer half).
REQ-002 Parameter: FRAME_CYC, default 1052, clk125 cycles the transmitter spends on one frame (preamble + payload + header + FCS).
REQ-003 Parameter: IFG_CYC, default 12, minimum idle clk125 cycles between frames.
REQ-004 Port: clk125, input, 1, the only clock; all logic on posedge.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: en, input, 1, high permits launching frames; filling continues regardless.
REQ-007 Port: wr_valid, input, 1, writer presents a payload byte.
REQ-008 Port: wr_data, input, 8, payload byte.
REQ-009 Port: wr_rdy, output, 1, the current fill half can accept a byte.
REQ-010 Port: buf_we, output, 1, payload RAM write strobe.
REQ-011 Port: buf_wa, output, 11, RAM write address {half, offset[9:0]}.
REQ-012 Port: buf_wd, output, 8, RAM write data.
REQ-013 Port: idx, output, 1, transmitter half select; each toggle launches one frame from half = new idx.
REQ-014 Port: frames_sent, output, 16, count of launched frames, wraps at 65535 -> 0.
REQ-015 Port: ovf, output, 1, sticky flag: a byte was offered while wr_rdy was low.

Function
REQ-016 Each half SHALL hold one state: EMPTY, FILLING, FULL, SENDING.
REQ-017 buf_we/buf_wa/buf_wd SHALL be registered: one cycle after an accepted byte (wr_valid & wr_rdy), buf_we=1, buf_wa={fill_half, wptr}, buf_wd=wr_data.
REQ-018 wptr SHALL increment per accepted byte; at PAYLOAD-1 the half SHALL become FULL, wptr SHALL wrap to 0 and fill_half SHALL toggle.
REQ-019 wr_rdy SHALL be high iff the fill half is EMPTY or FILLING; it is combinational from registered state.
REQ-020 wr_valid with wr_rdy low SHALL drop the byte, produce no RAM write and set ovf until reset.
REQ-021 The launch FSM SHALL have states IDLE, LAUNCH, SEND.
REQ-022 IDLE -> LAUNCH when en=1 and half (~idx) is FULL.
REQ-023 LAUNCH (one cycle): toggle idx, mark half new idx SENDING, increment frames_sent, load gap counter with FRAME_CYC+IFG_CYC-1; -> SEND.
REQ-024 SEND: decrement counter each cycle; at 0 mark the sending half EMPTY and -> IDLE.
REQ-025 Consecutive idx toggles SHALL therefore be at least FRAME_CYC+IFG_CYC+1 cycles apart (1065 at defaults).
REQ-026 Halves SHALL be sent strictly alternately, in fill order; a half SHALL never be written while SENDING.
REQ-027 Release (SEND->IDLE) and fill completion in the same cycle SHALL both take effect; a writer byte to the just-released half is accepted in the following cycle, not the release cycle.
REQ-028 en low SHALL not abort SEND; it only blocks the next IDLE->LAUNCH.

Reset
REQ-029 On rst: idx=1, fill_half=0, wptr=0, both halves EMPTY, FSM=IDLE, gap counter=0, buf_we=0, buf_wa=0, buf_wd=0, frames_sent=0, ovf=0.
REQ-030 rst mid-frame SHALL discard all buffered data; the first frame after reset is from half 0.

Structure
REQ-031 Shared package tx_pkg SHALL hold half_state_t (EMPTY/FILLING/FULL/SENDING), sched_state_t (IDLE/LAUNCH/SEND) and defaults PAYLOAD, FRAME_CYC, IFG_CYC.
REQ-032 One sub-module, tx_gap_timer (loadable down-counter with zero flag), is natural; all else flat.

Verification
REQ-033 Reset, write 1024 bytes 0..255 repeating with en=1 -> buf_wa 0..1023, half 0 FULL, idx 1->0 within 2 cycles, frames_sent=1.
REQ-034 Continuous 2048-byte stream -> second toggle (0->1) exactly 1065 cycles after the first; buf_wa 1024..2047 for the second half.
REQ-035 Write 3072 bytes back-to-back with no stalls -> wr_rdy low after byte 2048 until half 0 released, bytes held off (wr_valid held) not lost, ovf=0.
REQ-036 Force wr_valid during wr_rdy low -> no buf_we, ovf=1 and stays 1.
REQ-037 en=0 with both halves FULL -> idx constant; en=1 -> one toggle next cycle path, next after 1065 cycles.
REQ-038 Assert rst 500 cycles into SEND -> all outputs at REQ-029 values same cycle; next full half 0 launches idx 1->0.
